// File: rtl/conway_row_engine.sv
// Game of Life next-generation engine: takes a row and its two neighbours, scans one
// column per cycle and returns the next-generation row over a valid/ready handshake.
module conway_row_engine #(
  parameter int WIDTH = 8,
  parameter bit WRAP  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_above,
  input  logic [WIDTH-1:0] in_row,
  input  logic [WIDTH-1:0] in_below,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_row,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for a row triple, in_ready high
  // SCAN  | computing one output column per cycle from the registered rows
  // DONE  | out_row complete, out_valid high until downstream accepts

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     col;
  logic [WIDTH-1:0]  above_q, row_q, below_q, out_q;
  logic              accept;

  logic [CW-1:0]     lidx, ridx;
  logic              l_en, r_en;
  logic [1:0]        cs_l, cs_c, cs_r;
  logic [3:0]        n;
  logic              cell_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (col == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Neighbour columns; out-of-range ones are dead unless the row wraps.
  always_comb begin
    lidx = (col == '0)  ? LAST : col - CW'(1);
    ridx = (col == LAST) ? '0  : col + CW'(1);
    l_en = (col != '0)   || WRAP;
    r_en = (col != LAST) || WRAP;
    cs_c = {1'b0, above_q[col]} + {1'b0, row_q[col]} + {1'b0, below_q[col]};
    cs_l = l_en ? ({1'b0, above_q[lidx]} + {1'b0, row_q[lidx]} + {1'b0, below_q[lidx]}) : 2'd0;
    cs_r = r_en ? ({1'b0, above_q[ridx]} + {1'b0, row_q[ridx]} + {1'b0, below_q[ridx]}) : 2'd0;
    n        = {2'b00, cs_l} + {2'b00, cs_c} + {2'b00, cs_r} - {3'b000, row_q[col]};
    cell_nxt = (n == 4'd3) | (row_q[col] & (n == 4'd2));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      above_q <= '0;
      row_q   <= '0;
      below_q <= '0;
      out_q   <= '0;
      col     <= '0;
    end else if (accept) begin
      above_q <= in_above;
      row_q   <= in_row;
      below_q <= in_below;
      col     <= '0;
    end else if (state == SCAN) begin
      out_q[col] <= cell_nxt;
      col        <= col + CW'(1);
    end
  end

  assign out_row = out_q;

endmodule

// File: tb/tb_conway_row_engine.sv
// Directed bench for conway_row_engine: one WRAP=0 and one WRAP=1 instance driven in
// lockstep, checked against hand-computed next-generation rows.
module tb_conway_row_engine;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_above = '0, in_row = '0, in_below = '0;

  logic         in_ready0, out_valid0, busy0;
  logic         in_ready1, out_valid1, busy1;
  logic [W-1:0] out_row0, out_row1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  conway_row_engine #(.WIDTH(W), .WRAP(1'b0)) u_nowrap (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_above(in_above), .in_row(in_row), .in_below(in_below),
    .out_valid(out_valid0), .out_ready(out_ready), .out_row(out_row0), .busy(busy0));

  conway_row_engine #(.WIDTH(W), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_above(in_above), .in_row(in_row), .in_below(in_below),
    .out_valid(out_valid1), .out_ready(out_ready), .out_row(out_row1), .busy(busy1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic irdy, input logic ovld, input logic bsy);
    check({tag, ".in_ready"},  {in_ready1, in_ready0},   {irdy, irdy});
    check({tag, ".out_valid"}, {out_valid1, out_valid0}, {ovld, ovld});
    check({tag, ".busy"},      {busy1, busy0},           {bsy, bsy});
  endtask

  // Accept a triple, confirm WIDTH-cycle latency and both results; leaves engines in DONE.
  task automatic run_row(input string tag, input logic [W-1:0] a, input logic [W-1:0] r,
                         input logic [W-1:0] b, input logic [W-1:0] exp0,
                         input logic [W-1:0] exp1, input logic early_ready);
    in_above = a; in_row = r; in_below = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_above = ~a; in_row = ~r; in_below = ~b;
    out_ready = early_ready;
    check_ctrl({tag, ".scan"}, 1'b0, 1'b0, 1'b1);
    repeat (W - 1) @(posedge clk);
    #1;
    check({tag, ".early_valid"}, {out_valid1, out_valid0}, 2'b00);
    out_ready = 1'b0;
    @(posedge clk); #1;
    check_ctrl({tag, ".done"}, 1'b0, 1'b1, 1'b1);
    check({tag, ".row_nowrap"}, out_row0, exp0);
    check({tag, ".row_wrap"},   out_row1, exp1);
  endtask

  task automatic release_row(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_ctrl({tag, ".release"}, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_ctrl("reset", 1'b1, 1'b0, 1'b0);
    check("reset.out_row", {out_row1, out_row0}, 16'h0000);
    @(posedge clk); #2 reset_n = 1'b1;
    @(posedge clk); #1;

    run_row("blinker", 8'h08, 8'h08, 8'h08, 8'h1C, 8'h1C, 1'b0);
    release_row("blinker");
    check("idle_hold", {out_row1, out_row0}, 16'h1C1C);

    run_row("blank", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    release_row("blank");

    run_row("edge", 8'h01, 8'h01, 8'h01, 8'h03, 8'h83, 1'b0);
    release_row("edge");

    run_row("crowd", 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0);
    release_row("crowd");

    run_row("bp", 8'h08, 8'h08, 8'h08, 8'h1C, 8'h1C, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_above = 8'hFF; in_row = 8'h55; in_below = 8'hAA;
      @(posedge clk); #1;
      check_ctrl("bp.hold", 1'b0, 1'b1, 1'b1);
      check("bp.row", {out_row1, out_row0}, 16'h1C1C);
    end
    in_valid = 1'b0;
    release_row("bp");
    run_row("b2b1", 8'h01, 8'h01, 8'h01, 8'h03, 8'h83, 1'b0);
    release_row("b2b1");
    run_row("b2b2", 8'h80, 8'h80, 8'h80, 8'hC0, 8'hC1, 1'b0);
    release_row("b2b2");

    in_above = 8'h08; in_row = 8'h08; in_below = 8'h08; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_ctrl("midreset", 1'b1, 1'b0, 1'b0);
    check("midreset.out_row", {out_row1, out_row0}, 16'h0000);
    #1 reset_n = 1'b1;
    run_row("post_reset", 8'h08, 8'h08, 8'h08, 8'h1C, 8'h1C, 1'b0);
    release_row("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
